// File: rtl/pulse_queue_if.sv
// -----------------------------------------------------------------------------
// pulse_queue_if
// Purpose : bundles the event-side and pulse-CDC-side signals of pulse_queue.
// Signals :
//   evt_in    - event request, one cycle per event (driver -> queue)
//   cdc_done  - handshake-complete pulse from the pulse-CDC acknowledge
//   err_clr   - clears the sticky error flags
//   pulse_out - single-cycle pulse towards the pulse-CDC stage
//   pend_cnt  - accepted events not yet issued
//   busy      - queue FSM is not idle
//   ovf       - sticky: an event was dropped
//   tmo_err   - sticky: a handshake timed out
// Modports: master = event source / CDC side, slave = pulse_queue itself.
// -----------------------------------------------------------------------------
interface pulse_queue_if #(
    parameter int CNT_W = 4
);
    logic             evt_in;
    logic             cdc_done;
    logic             err_clr;
    logic             pulse_out;
    logic [CNT_W-1:0] pend_cnt;
    logic             busy;
    logic             ovf;
    logic             tmo_err;

    modport master (
        output evt_in, cdc_done, err_clr,
        input  pulse_out, pend_cnt, busy, ovf, tmo_err
    );

    modport slave (
        input  evt_in, cdc_done, err_clr,
        output pulse_out, pend_cnt, busy, ovf, tmo_err
    );
endinterface

// File: rtl/pulse_queue.sv
// -----------------------------------------------------------------------------
// pulse_queue
// Purpose : counts incoming single-cycle events and forwards them one at a time
//           to a pulse-CDC stage, waiting for its acknowledge (cdc_done) before
//           issuing the next one, with a guard gap after every handshake and a
//           timeout that abandons a handshake that never completes.
// Params  : CNT_W - pending counter width (capacity 2^CNT_W-1)
//           TMO   - WAIT cycles before a handshake is abandoned (2..255)
//           GAP   - idle cycles after each handshake (0..15)
// Ports   : clk - rising-edge clock
//           rst - synchronous active-high reset
//           bus - pulse_queue_if.slave (evt_in, cdc_done, err_clr in;
//                 pulse_out, pend_cnt, busy, ovf, tmo_err out)
// -----------------------------------------------------------------------------
module pulse_queue #(
    parameter int CNT_W = 4,
    parameter int TMO   = 64,
    parameter int GAP   = 2
) (
    input  logic          clk,
    input  logic          rst,
    pulse_queue_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WAIT   = 2'd1,
        GAP_ST = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] PMAX     = {CNT_W{1'b1}};
    localparam logic [7:0]       TMO_LAST = 8'(TMO - 1);
    localparam logic [3:0]       GAP_LD   = 4'(GAP);

    state_t           state_q, state_d;
    logic [7:0]       tmr_q, tmr_d;
    logic [3:0]       gap_q, gap_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             pulse_q, busy_q, ovf_q, tmo_q;

    logic iss;      // event leaves the queue (IDLE -> WAIT)
    logic acc;      // evt_in is accepted into the queue
    logic drop;     // evt_in arrived with no room
    logic tmo_hit;  // handshake abandoned this cycle

    always_comb begin
        state_d = state_q;
        tmr_d   = tmr_q;
        gap_d   = gap_q;
        iss     = 1'b0;
        tmo_hit = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (cnt_q != '0 || bus.evt_in) begin
                    state_d = WAIT;
                    iss     = 1'b1;
                    tmr_d   = '0;
                end
            end
            WAIT: begin
                // cdc_done takes priority, so a done on the last timer cycle
                // still counts as a successful handshake.
                if (bus.cdc_done || tmr_q == TMO_LAST) begin
                    tmo_hit = ~bus.cdc_done;
                    if (GAP == 0) begin
                        state_d = IDLE;
                    end else begin
                        state_d = GAP_ST;
                        gap_d   = GAP_LD;
                    end
                end else begin
                    tmr_d = tmr_q + 8'd1;
                end
            end
            GAP_ST: begin
                if (gap_q <= 4'd1) begin
                    state_d = IDLE;
                end else begin
                    gap_d = gap_q - 4'd1;
                end
            end
            default: state_d = IDLE;
        endcase

        // A full queue still takes an event when one leaves in the same cycle.
        acc   = bus.evt_in && (cnt_q != PMAX || iss);
        drop  = bus.evt_in && !acc;
        cnt_d = cnt_q + CNT_W'(acc) - CNT_W'(iss);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            tmr_q   <= '0;
            gap_q   <= '0;
            cnt_q   <= '0;
            pulse_q <= 1'b0;
            busy_q  <= 1'b0;
            ovf_q   <= 1'b0;
            tmo_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            tmr_q   <= tmr_d;
            gap_q   <= gap_d;
            cnt_q   <= cnt_d;
            pulse_q <= iss;
            busy_q  <= (state_d != IDLE);
            // Setting a flag wins over clearing it in the same cycle.
            ovf_q   <= drop    | (ovf_q & ~bus.err_clr);
            tmo_q   <= tmo_hit | (tmo_q & ~bus.err_clr);
        end
    end

    assign bus.pulse_out = pulse_q;
    assign bus.pend_cnt  = cnt_q;
    assign bus.busy      = busy_q;
    assign bus.ovf       = ovf_q;
    assign bus.tmo_err   = tmo_q;

endmodule

// File: tb/tb_pulse_queue.sv
module tb_pulse_queue;
    localparam int CNT_W = 4;
    localparam int TMO   = 64;
    localparam int GAP   = 2;
    localparam int PMAX  = (1 << CNT_W) - 1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    pulse_queue_if #(.CNT_W(CNT_W)) bus ();

    pulse_queue #(.CNT_W(CNT_W), .TMO(TMO), .GAP(GAP)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks = 0;
    int errors = 0;

    // reference model: queue depth plus handshake timeline in absolute cycles
    int cyc         = 0;
    int m_pend      = 0;
    bit m_wait      = 0;
    int m_issue     = 0;   // cycle in which the current pulse is high
    int m_idle_from = 0;   // first cycle in which the queue may issue again
    bit m_ovf       = 0;
    bit m_tmo       = 0;
    bit m_pulse     = 0;
    bit m_busy      = 0;

    // observation bookkeeping
    int pulses     = 0;
    int peak       = 0;
    int last_pulse = -1;
    int min_sep    = 1000;

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // inputs seen at the edge that ends cycle t (=cyc); state describes cycle t+1
    task automatic model(bit r, bit e, bit d, bit c);
        bit iss;
        bit set_ovf;
        bit set_tmo;
        int t;
        t = cyc;
        if (r) begin
            m_pend = 0; m_wait = 0; m_idle_from = 0;
            m_ovf = 0; m_tmo = 0; m_pulse = 0; m_busy = 0;
            return;
        end
        iss = 0; set_ovf = 0; set_tmo = 0;
        if (!m_wait && t >= m_idle_from) begin
            if (m_pend > 0 || e) begin
                iss = 1;
                m_wait = 1;
                m_issue = t + 1;
            end
        end else if (m_wait) begin
            if (d || (t - m_issue) == TMO - 1) begin
                m_wait = 0;
                m_idle_from = t + 1 + GAP;
                set_tmo = !d;
            end
        end
        if (e) begin
            if (m_pend < PMAX || iss) m_pend++;
            else set_ovf = 1;
        end
        if (iss) m_pend--;
        m_ovf   = set_ovf ? 1'b1 : (c ? 1'b0 : m_ovf);
        m_tmo   = set_tmo ? 1'b1 : (c ? 1'b0 : m_tmo);
        m_pulse = iss;
        m_busy  = m_wait || (t + 1 < m_idle_from);
    endtask

    task automatic step(bit r, bit e, bit d, bit c);
        rst = r; bus.evt_in = e; bus.cdc_done = d; bus.err_clr = c;
        @(posedge clk);
        model(r, e, d, c);
        cyc++;
        #1;
        chk("pulse_out", bus.pulse_out, m_pulse);
        chk("pend_cnt",  bus.pend_cnt,  m_pend);
        chk("busy",      bus.busy,      m_busy);
        chk("ovf",       bus.ovf,       m_ovf);
        chk("tmo_err",   bus.tmo_err,   m_tmo);
        if (bus.pulse_out === 1'b1) begin
            pulses++;
            if (last_pulse >= 0 && cyc - last_pulse < min_sep) min_sep = cyc - last_pulse;
            last_pulse = cyc;
        end
        if (int'(bus.pend_cnt) > peak) peak = int'(bus.pend_cnt);
    endtask

    // reactive CDC side: answers each pulse after a delay drawn from [dmin,dmax];
    // dmax < 0 means never answer
    task automatic run(int n, int burst, int evt_pct, int dmin, int dmax,
                       int clr_pct, int rst_pml);
        int cd;
        bit e, d, c, r;
        cd = -1;
        for (int i = 0; i < n; i++) begin
            d = (cd == 0);
            if (cd >= 0) cd--;
            e = (i < burst) || ($urandom_range(99) < evt_pct);
            c = ($urandom_range(99) < clr_pct);
            r = ($urandom_range(999) < rst_pml);
            step(r, e, d, c);
            if (r) cd = -1;
            if (bus.pulse_out === 1'b1 && dmax >= 0) cd = $urandom_range(dmax, dmin);
        end
    endtask

    initial begin
        int p0;
        int tmo_at;
        bus.evt_in = 0; bus.cdc_done = 0; bus.err_clr = 0;

        // reset state
        step(1, 1, 1, 0);
        step(1, 0, 0, 0);
        chk("rst_pulse", bus.pulse_out, 0);
        chk("rst_pend",  bus.pend_cnt,  0);
        chk("rst_busy",  bus.busy,      0);
        chk("rst_flags", {bus.ovf, bus.tmo_err}, 0);

        // single event: pulse next cycle, queue stays empty, done 5 cycles later
        pulses = 0;
        step(0, 1, 0, 0);
        chk("lat_pulse", bus.pulse_out, 1);
        chk("lat_pend",  bus.pend_cnt,  0);
        repeat (4) step(0, 0, 0, 0);
        step(0, 0, 1, 0);
        repeat (6) step(0, 0, 0, 0);
        chk("single_pulses", pulses, 1);
        chk("single_idle",   bus.busy, 0);

        // burst of three, done 3 cycles after each pulse
        pulses = 0; peak = 0; last_pulse = -1; min_sep = 1000;
        run(40, 3, 0, 3, 3, 0, 0);
        chk("burst_pulses", pulses, 3);
        chk("burst_peak",   peak,   2);
        chk("burst_sep_ok", (min_sep >= 3 + GAP), 1);

        // fill while stuck in WAIT, then clear overflow
        step(1, 0, 0, 0);
        step(0, 1, 0, 0);
        p0 = last_pulse;
        repeat (16) step(0, 1, 0, 0);
        chk("fill_pend", bus.pend_cnt, PMAX);
        chk("fill_ovf",  bus.ovf,      1);
        step(0, 0, 0, 1);
        chk("clr_ovf",   bus.ovf,      0);

        // no done: timeout 64 cycles after the pulse
        tmo_at = -1;
        for (int i = 0; i < 100 && tmo_at < 0; i++) begin
            step(0, 0, 0, 0);
            if (bus.tmo_err === 1'b1) tmo_at = cyc;
        end
        chk("tmo_delay", tmo_at - p0, TMO);

        // back in IDLE with a full queue: issue and accept in the same cycle
        for (int i = 0; i < 10 && bus.busy === 1'b1; i++) step(0, 0, 0, 0);
        chk("full_idle", bus.busy, 0);
        step(0, 1, 0, 0);
        chk("full_iss_pulse", bus.pulse_out, 1);
        chk("full_iss_pend",  bus.pend_cnt,  PMAX);
        chk("full_iss_ovf",   bus.ovf,       0);

        // reset in WAIT with four pending, then a late done
        step(1, 0, 0, 0);
        repeat (5) step(0, 1, 0, 0);
        chk("mid_pend", bus.pend_cnt, 4);
        step(1, 0, 0, 0);
        chk("mid_rst_out", {bus.pulse_out, bus.busy, bus.ovf, bus.tmo_err}, 0);
        chk("mid_rst_pend", bus.pend_cnt, 0);
        step(0, 0, 1, 0);
        chk("late_done_busy", bus.busy, 0);
        chk("late_done_tmo",  bus.tmo_err, 0);
        chk("late_done_pulse", bus.pulse_out, 0);

        // randomized phases against the model
        run(1500, 0, 40, 0, 8, 2, 2);
        run(1500, 0, 10, 0, 80, 3, 1);
        run(800, 0, 70, 0, -1, 1, 2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/pulse_queue.md
PULSE_QUEUE -- requirements
Module: pulse_queue

Interface
REQ-001 Parameter CNT_W, default 4: pending-event counter width; capacity PMAX = 2^CNT_W - 1.
REQ-002 Parameter TMO, default 64: cycles to wait for cdc_done before aborting; legal range 2..255.
REQ-003 Parameter GAP, default 2: idle cycles after each handshake; legal range 0..15.
REQ-004 Port clk  input  1: single clock; all logic on rising edge.
REQ-005 Port rst  input  1: synchronous, active-high reset.
REQ-006 Port evt_in  input  1: event request, one cycle per event, back-to-back allowed.
REQ-007 Port cdc_done  input  1: single-cycle handshake-complete pulse from the downstream pulse-CDC stage's acknowledge.
REQ-008 Port err_clr  input  1: clears sticky error flags.
REQ-009 Port pulse_out  output  1: registered single-cycle pulse to the pulse-CDC stage input.
REQ-010 Port pend_cnt  output  CNT_W: accepted events not yet issued.
REQ-011 Port busy  output  1: high whenever FSM is not IDLE.
REQ-012 Port ovf  output  1: sticky, an event was dropped.
REQ-013 Port tmo_err  output  1: sticky, a handshake timed out.

Function
REQ-014 The FSM SHALL have states IDLE, WAIT, GAP_ST; at most one pulse_out SHALL be outstanding at any time.
REQ-015 IDLE: if pend_cnt != 0 or evt_in = 1, next state WAIT and pulse_out = 1 in the first WAIT cycle; otherwise stay IDLE.
REQ-016 pulse_out SHALL be high for exactly one cycle per WAIT entry, never in IDLE or GAP_ST.
REQ-017 Latency: evt_in high at edge t, FSM IDLE, pend_cnt 0 -> pulse_out high in cycle t+1, pend_cnt stays 0.
REQ-018 pend_cnt next = pend_cnt + acc - iss, where iss = 1 on the IDLE->WAIT transition and acc = accepted evt_in.
REQ-019 evt_in SHALL be accepted when pend_cnt < PMAX, or when pend_cnt = PMAX and iss = 1 in the same cycle.
REQ-020 evt_in not accepted SHALL be dropped, pend_cnt unchanged, and ovf set on the next edge.
REQ-021 WAIT: a wait timer SHALL clear on entry and increment each cycle; cdc_done = 1 -> GAP_ST.
REQ-022 WAIT: timer reaching TMO-1 without cdc_done -> tmo_err set and GAP_ST; the issued event is not re-queued.
REQ-023 cdc_done and timeout in the same cycle SHALL be treated as success: tmo_err not set.
REQ-024 cdc_done in IDLE or GAP_ST SHALL be ignored with no state or flag change.
REQ-025 The cdc_done pulse in the cycle pulse_out is high SHALL be honoured (one-cycle minimum handshake).
REQ-026 GAP_ST: a counter SHALL load GAP on entry and stay GAP cycles, then IDLE; with GAP = 0, WAIT exits directly to IDLE.
REQ-027 evt_in SHALL be accepted in every state subject only to REQ-019.
REQ-028 err_clr SHALL clear ovf and tmo_err on the next edge; a set condition in the same cycle wins over err_clr.
REQ-029 busy SHALL be a registered decode of state != IDLE.

Reset
REQ-030 rst high at a clock edge SHALL force state IDLE, pend_cnt 0, pulse_out 0, busy 0, ovf 0, tmo_err 0, and clear all timers.
REQ-031 rst asserted mid-handshake SHALL discard pending and in-flight events, with no pulse_out in the cycle after reset.
REQ-032 While rst is high, evt_in and cdc_done SHALL be ignored.

Verification
REQ-033 Single event with defaults, cdc_done 5 cycles after pulse_out -> one pulse_out; busy high for 5 + 2 cycles; pend_cnt 0 throughout.
REQ-034 Burst of 3 back-to-back evt_in, cdc_done 3 cycles after each pulse_out -> pend_cnt peaks at 2; exactly 3 pulse_out, each separated by at least 3 + GAP cycles.
REQ-035 Fill: 16 evt_in while stuck in WAIT (CNT_W = 4) -> pend_cnt saturates at 15, ovf = 1; err_clr -> ovf = 0.
REQ-036 No cdc_done -> tmo_err set 64 cycles after pulse_out; FSM returns to IDLE after GAP; next queued event issues.
REQ-037 evt_in at pend_cnt = 15 in the same cycle as the IDLE->WAIT issue -> accepted, pend_cnt stays 15, ovf stays 0.
REQ-038 rst asserted in WAIT with pend_cnt = 4 -> next cycle all outputs 0 and state IDLE; a late cdc_done is ignored.
